fwd_mux_pipe: RTL and testbench

FWD_MUX_PIPE -- requirements
Module: fwd_mux_pipe

---
 rtl/fwd_mux_pipe.sv | 169 ++++++++++++++++
 tb/tb_fwd_mux_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_mux_pipe.sv
// Registered N-to-1 forwarding mux with a valid/ready handshake on both sides.
// Define FWD_MUX_SKID_EN for a two-entry skid buffer with registered in_ready_o.
//
// state | meaning
// EMPTY | nothing stored, out_valid_o low
// ONE   | output register holds the oldest entry
// TWO   | output register plus skid entry held (skid build only)
module fwd_mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        data_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_IN - 1);

  state_t           state;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;
  logic [SEL_W-1:0] sel_c;
  logic [WIDTH-1:0] mux_data;
  logic             ready;
  logic             accept;
  logic             xfer;

  // Out-of-range selects clamp to the last input.
  always_comb begin
    sel_c = (select_i > MAX_SEL) ? MAX_SEL : select_i;
  end

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_c == SEL_W'(k)) mux_data = data_i[k*WIDTH +: WIDTH];
    end
  end

  assign accept      = in_valid_i && ready && !flush_i;
  assign xfer        = out_valid && out_ready_i;
  assign in_ready_o  = ready;
  assign data_o      = out_data;
  assign sel_o       = out_sel;
  assign out_valid_o = out_valid;

`ifdef FWD_MUX_SKID_EN

  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             ready_q;

  assign ready = ready_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
      ready_q   <= 1'b1;
    end else if (flush_i) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_sel   <= sel_c;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            out_data <= mux_data;
            out_sel  <= sel_c;
          end else if (accept) begin
            // Downstream stalled: park the new entry behind the output.
            state     <= TWO;
            skid_data <= mux_data;
            skid_sel  <= sel_c;
            ready_q   <= 1'b0;
          end else if (xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (xfer) begin
            state    <= ONE;
            out_data <= skid_data;
            out_sel  <= skid_sel;
            ready_q  <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

`else

  assign ready = !out_valid || out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (flush_i) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_sel   <= sel_c;
          end
        end
        ONE: begin
          // An accept here implies a same-cycle transfer, so the slot is replaced.
          if (accept) begin
            out_data <= mux_data;
            out_sel  <= sel_c;
          end else if (xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// Self-checking bench for fwd_mux_pipe: directed literal cases, then random
// traffic compared every cycle against a queue-based model.
module tb_fwd_mux_pipe;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [NUM_IN*WIDTH-1:0] data_i;
  logic [SEL_W-1:0]        select_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic                    flush_i;
  logic [WIDTH-1:0]        data_o;
  logic [SEL_W-1:0]        sel_o;
  logic                    out_valid_o;
  logic                    out_ready_i;

  fwd_mux_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .select_i   (select_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .flush_i    (flush_i),
    .data_o     (data_o),
    .sel_o      (sel_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic [31:0] s;
  } entry_t;

  entry_t mq[$];
  int     checks   = 0;
  int     failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
`ifdef FWD_MUX_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || (out_ready_i == 1'b1);
`endif
  endfunction

  // Model: a FIFO of accepted entries, capacity 1 (or 2 with skid).
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mq.delete();
    end else begin
      automatic bit acc = in_valid_i && exp_ready() && !flush_i;
      automatic bit xfr = (mq.size() > 0) && out_ready_i;
      if (flush_i) begin
        mq.delete();
      end else begin
        if (xfr) mq.delete(0);
        if (acc) begin
          automatic int     s = int'(select_i);
          automatic entry_t e;
          if (s >= NUM_IN) s = NUM_IN - 1;
          e.s = 32'(s);
          e.d = data_i[s*WIDTH +: WIDTH];
          mq.push_back(e);
        end
      end
    end
  end

  always @(negedge clk_i) begin
    check("model_out_valid", 32'(out_valid_o), 32'(mq.size() > 0));
    check("model_in_ready", 32'(in_ready_o), 32'(exp_ready()));
    if (!rst_i) check("model_reset_data", data_o, 32'h0);
    else if (mq.size() > 0) begin
      check("model_data", data_o, mq[0].d);
      check("model_sel", 32'(sel_o), mq[0].s);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i       = 1'b0;
    in_valid_i  = 1'b0;
    select_i    = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    data_i      = {32'h33, 32'h22, 32'h11};
    #2;
    check("reset_valid", 32'(out_valid_o), 32'h0);
    check("reset_data", data_o, 32'h0);
    check("reset_sel", 32'(sel_o), 32'h0);
    check("reset_ready", 32'(in_ready_o), 32'h1);
    step();
    rst_i      = 1'b1;
    in_valid_i = 1'b1;
    select_i   = 2'd1;
    step();
    check("sel1_valid", 32'(out_valid_o), 32'h1);
    check("sel1_data", data_o, 32'h22);
    check("sel1_sel", 32'(sel_o), 32'h1);
    select_i = 2'd3;
    step();
    check("clamp_data", data_o, 32'h33);
    check("clamp_sel", 32'(sel_o), 32'h2);
    for (int i = 0; i < 3; i++) begin
      select_i = 2'(i);
      step();
      check("b2b_valid", 32'(out_valid_o), 32'h1);
      check("b2b_data", data_o, 32'h11 * 32'(i + 1));
    end
    // Output holds 0x33; stall downstream while offering 0x11.
    out_ready_i = 1'b0;
    select_i    = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", data_o, 32'h33);
      check("stall_valid", 32'(out_valid_o), 32'h1);
    end
    check("stall_ready", 32'(in_ready_o), 32'h0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
`ifdef FWD_MUX_SKID_EN
    check("release_data", data_o, 32'h11);
    check("release_valid", 32'(out_valid_o), 32'h1);
`else
    check("release_valid", 32'(out_valid_o), 32'h0);
`endif
    step();
    check("drained_valid", 32'(out_valid_o), 32'h0);
    // Fill (ONE, and TWO with skid), then flush with a same-cycle offer.
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    select_i    = 2'd1;
    step();
    select_i = 2'd2;
    step();
    flush_i  = 1'b1;
    select_i = 2'd0;
    step();
    check("flush_valid", 32'(out_valid_o), 32'h0);
    check("flush_ready", 32'(in_ready_o), 32'h1);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    step();
    check("flush_gone", 32'(out_valid_o), 32'h0);
    in_valid_i = 1'b1;
    select_i   = 2'd1;
    step();
    in_valid_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid_o), 32'h0);
    check("async_rst_data", data_o, 32'h0);
    check("async_rst_ready", 32'(in_ready_o), 32'h1);
    rst_i = 1'b1;
    step();

    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NUM_IN; k++) data_i[k*WIDTH +: WIDTH] = $urandom;
      in_valid_i  = ($urandom_range(0, 3) != 0);
      select_i    = 2'($urandom_range(0, 3));
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 249) == 0) begin
        #1 rst_i = 1'b0;
        #1 rst_i = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
